// File: rtl/odd_count_checker.sv
// Receive-side checker for an odd-number count stream: locks onto 1, 3, 5, ...
// (step STEP, modulo 2^WIDTH), flywheels through isolated errors, counts errors.
module odd_count_checker #(
   parameter int WIDTH      = 8,
   parameter int STEP       = 2,
   parameter int LOCK_CNT   = 2,
   parameter int ERR_THRESH = 4,
   parameter int ERRCNT_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [WIDTH-1:0]    count_in,
   output logic                locked,
   output logic                mismatch,
   output logic [WIDTH-1:0]    expected,
   output logic [ERRCNT_W-1:0] err_count
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int EW = $clog2(ERR_THRESH + 1);
   localparam logic [WIDTH-1:0] STEP_V   = WIDTH'(STEP);
   localparam logic [MW-1:0]    LOCK_V   = MW'(LOCK_CNT);
   localparam logic [EW-1:0]    THRESH_V = EW'(ERR_THRESH);

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      exp_q, exp_d;
   logic [MW-1:0]         match_q, match_d;
   logic [EW-1:0]         miss_q, miss_d;
   logic [ERRCNT_W-1:0]   err_q, err_d;
   logic                  mis_q, mis_d;
   logic                  lock_q;

   logic                  odd_in;
   logic                  hit;
   logic [WIDTH-1:0]      seed;
   logic [WIDTH-1:0]      flywheel;
   logic [MW-1:0]         match_inc;
   logic [EW-1:0]         miss_inc;

   assign odd_in    = count_in[0];
   assign hit       = odd_in && (count_in == exp_q);
   assign seed      = count_in + STEP_V;
   assign flywheel  = exp_q + STEP_V;
   assign match_inc = match_q + MW'(1);
   assign miss_inc  = miss_q + EW'(1);

   // State and datapath registers
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      if (rst) begin
         state_q <= HUNT;
         exp_q   <= '0;
         match_q <= '0;
         miss_q  <= '0;
         err_q   <= '0;
         mis_q   <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         match_q <= match_d;
         miss_q  <= miss_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
         lock_q  <= (state_d == LOCKED);
      end
   end

   // Next-state and next-datapath logic
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a variable
      // unassigned, which would infer a latch.
      state_d = state_q;
      exp_d   = exp_q;
      match_d = match_q;
      miss_d  = miss_q;
      mis_d   = 1'b0;
      err_d   = err_q;

      if (in_valid) begin
         case (state_q)
            HUNT: begin
               if (odd_in) begin
                  exp_d   = seed;
                  match_d = MW'(1);
                  miss_d  = '0;
                  state_d = (LOCK_CNT == 1) ? LOCKED : SYNC;
               end else begin
                  mis_d = 1'b1;
               end
            end
            SYNC: begin
               if (hit) begin
                  exp_d   = flywheel;
                  match_d = match_inc;
                  if (match_inc == LOCK_V) begin
                     state_d = LOCKED;
                     miss_d  = '0;
                  end
               end else if (odd_in) begin
                  mis_d   = 1'b1;
                  exp_d   = seed;
                  match_d = MW'(1);
               end else begin
                  mis_d   = 1'b1;
                  state_d = HUNT;
               end
            end
            LOCKED: begin
               exp_d = flywheel;
               if (hit) begin
                  miss_d = '0;
               end else begin
                  mis_d = 1'b1;
                  if (miss_inc == THRESH_V) begin
                     state_d = HUNT;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss_inc;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end

      // Saturating error counter
      if (mis_d && (err_q != '1))
         err_d = err_q + ERRCNT_W'(1);
   end

   // Outputs come straight from flops
   always_comb begin
      locked    = lock_q;
      mismatch  = mis_q;
      expected  = exp_q;
      err_count = err_q;
   end

endmodule

// File: tb/tb_odd_count_checker.sv
// Self-checking bench for odd_count_checker: directed test-plan sequences with
// literal expectations plus randomized traffic checked against a behavioural model.
module tb_odd_count_checker;

   localparam int WIDTH      = 8;
   localparam int STEP       = 2;
   localparam int LOCK_CNT   = 2;
   localparam int ERR_THRESH = 4;
   localparam int ERRCNT_W   = 8;
   localparam int MODV       = 1 << WIDTH;
   localparam int ERR_MAX    = (1 << ERRCNT_W) - 1;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                in_valid = 1'b0;
   logic [WIDTH-1:0]    count_in = '0;
   logic                locked;
   logic                mismatch;
   logic [WIDTH-1:0]    expected;
   logic [ERRCNT_W-1:0] err_count;

   int tests = 0;
   int fails = 0;
   bit cmp_en = 1'b0;

   odd_count_checker #(
      .WIDTH(WIDTH), .STEP(STEP), .LOCK_CNT(LOCK_CNT),
      .ERR_THRESH(ERR_THRESH), .ERRCNT_W(ERRCNT_W)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .count_in(count_in),
      .locked(locked), .mismatch(mismatch), .expected(expected),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: mode 0 = hunting, 1 = confirming, 2 = locked
   int m_mode, m_exp, m_match, m_miss, m_err, m_x;
   bit m_mis, m_good;

   always @(posedge clk) begin
      m_mis = 1'b0;
      if (rst) begin
         m_mode = 0; m_exp = 0; m_match = 0; m_miss = 0; m_err = 0;
      end else if (in_valid) begin
         m_x    = int'(count_in);
         m_good = (m_mode == 0) ? (m_x % 2 == 1) : (m_x == m_exp);
         if (!m_good) begin
            m_mis = 1'b1;
            if (m_err < ERR_MAX) m_err = m_err + 1;
         end
         case (m_mode)
            0: if (m_good) begin
                  m_exp = (m_x + STEP) % MODV;
                  m_match = 1;
                  m_mode = (LOCK_CNT == 1) ? 2 : 1;
               end
            1: if (m_good) begin
                  m_exp = (m_exp + STEP) % MODV;
                  m_match = m_match + 1;
                  if (m_match >= LOCK_CNT) begin m_mode = 2; m_miss = 0; end
               end else if (m_x % 2 == 1) begin
                  m_exp = (m_x + STEP) % MODV;
                  m_match = 1;
               end else begin
                  m_mode = 0;
               end
            default: begin
               m_exp = (m_exp + STEP) % MODV;
               if (m_good) m_miss = 0;
               else begin
                  m_miss = m_miss + 1;
                  if (m_miss >= ERR_THRESH) begin m_mode = 0; m_miss = 0; end
               end
            end
         endcase
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         check("model.locked",    int'(locked),    int'(m_mode == 2));
         check("model.mismatch",  int'(mismatch),  int'(m_mis));
         check("model.expected",  int'(expected),  m_exp);
         check("model.err_count", int'(err_count), m_err);
      end
   end

   // One cycle: drive at negedge, return at the next negedge with results visible
   task automatic cyc(input bit r, input bit v, input int d);
      rst      = r;
      in_valid = v;
      count_in = WIDTH'(d);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0);
   endtask

   int r, d;

   initial begin
      @(negedge clk);
      do_reset(2);
      cmp_en = 1'b1;
      check("reset.locked", int'(locked), 0);
      check("reset.mismatch", int'(mismatch), 0);
      check("reset.expected", int'(expected), 0);
      check("reset.err_count", int'(err_count), 0);

      // Basic lock: 1, 3, 5
      cyc(0, 1, 1);
      check("basic.locked_after_1", int'(locked), 0);
      cyc(0, 1, 3);
      check("basic.locked_after_3", int'(locked), 1);
      cyc(0, 1, 5);
      check("basic.expected", int'(expected), 7);
      check("basic.err_count", int'(err_count), 0);

      // Wrap across 255 -> 1
      do_reset(1);
      cyc(0, 1, 253);
      cyc(0, 1, 255);
      check("wrap.locked", int'(locked), 1);
      check("wrap.expected_255", int'(expected), 1);
      cyc(0, 1, 1);
      check("wrap.mismatch_at_1", int'(mismatch), 0);
      cyc(0, 1, 3);
      check("wrap.expected", int'(expected), 5);

      // Single glitch flywheels
      do_reset(1);
      cyc(0, 1, 1); cyc(0, 1, 3); cyc(0, 1, 5);
      cyc(0, 1, 'h47);
      check("glitch.mismatch", int'(mismatch), 1);
      check("glitch.err_count", int'(err_count), 1);
      check("glitch.locked", int'(locked), 1);
      cyc(0, 1, 9);
      check("glitch.match9", int'(mismatch), 0);
      cyc(0, 1, 11);
      check("glitch.expected", int'(expected), 13);

      // Loss of lock after ERR_THRESH misses, then relock
      do_reset(1);
      cyc(0, 1, 1); cyc(0, 1, 3); cyc(0, 1, 5);
      for (int i = 1; i <= 4; i++) begin
         cyc(0, 1, 'h20);
         check("loss.mismatch", int'(mismatch), 1);
         check("loss.locked", int'(locked), (i < 4) ? 1 : 0);
      end
      check("loss.err_count", int'(err_count), 4);
      cyc(0, 1, 21);
      cyc(0, 1, 23);
      check("relock.locked", int'(locked), 1);
      check("relock.expected", int'(expected), 25);

      // Valid gaps are transparent
      do_reset(1);
      cyc(0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0);
         check("gap.mismatch", int'(mismatch), 0);
      end
      cyc(0, 1, 3);
      check("gap.locked", int'(locked), 1);
      check("gap.expected", int'(expected), 5);

      // Reset mid-lock with err_count=2
      do_reset(1);
      cyc(0, 1, 1); cyc(0, 1, 3); cyc(0, 1, 5);
      cyc(0, 1, 'h47); cyc(0, 1, 'h49);
      check("midrst.pre_err", int'(err_count), 2);
      check("midrst.pre_locked", int'(locked), 1);
      cyc(1, 1, 9);
      check("midrst.locked", int'(locked), 0);
      check("midrst.err_count", int'(err_count), 0);
      check("midrst.expected", int'(expected), 0);
      cyc(0, 1, 'h10);
      check("midrst.even_mismatch", int'(mismatch), 1);
      check("midrst.even_err", int'(err_count), 1);

      // err_count saturation
      for (int i = 0; i < 300; i++) cyc(0, 1, 0);
      check("sat.err_count", int'(err_count), ERR_MAX);
      cyc(0, 1, 0);
      check("sat.hold", int'(err_count), ERR_MAX);

      // Randomized traffic
      do_reset(1);
      for (int i = 0; i < 4000; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 60)      d = m_exp;
         else if (r < 75) d = int'($urandom_range(0, MODV - 1)) | 1;
         else if (r < 85) d = int'($urandom_range(0, MODV - 1)) & ~1;
         else             d = int'($urandom_range(0, MODV - 1));
         cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7), d);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
